mux_simples: RTL and testbench
==============================

Name: mux_simples

Overview:
- 2:1 selector with a combinational data path: y = s ? b : a.
- Adds a registered copy of the output and a saturating counter of select transitions for observability.
- Leaf block, used wherever a simple steerable bit or bus is needed; the combinational path never depends on the clock.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 8, width of the select-toggle counter.

Ports:
- clk  input  1  rising-edge clock for all registered state.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  data input selected when s=0.
- b  input  WIDTH  data input selected when s=1.
- s  input  1  select.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  y registered on clk.
- toggle_cnt  output  CNT_W  number of s transitions sampled on clk, saturating.
- s_q  output  1  s registered on clk.

Behaviour:
- Combinational path, purely combinational with zero latency:
  - y = a when s=0; y = b when s=1.
  - Unaffected by clk and rst; valid during reset.
  - s = X/Z: y = X on bits where a and b differ, equal to the common value where they match (standard ?: semantics).
- Registered path:
  - On posedge clk with rst=0: y_q <= y, s_q <= s.
  - y_q lags y by exactly 1 cycle.
- Toggle counter:
  - On posedge clk with rst=0: if s != s_q, toggle_cnt increments by 1.
  - Saturates at 2^CNT_W-1 and holds; no wrap.
  - The first posedge after reset release compares s against the reset value s_q=0, so s=1 at that edge counts as one toggle.
- Reset:
  - rst asserted, asynchronously at any time: y_q=0, s_q=0, toggle_cnt=0 immediately, without waiting for a clock edge.
  - Reset mid-operation discards the counter value.
  - On deassertion, registers update on the next posedge.
- Simultaneous events: a change in s coincident with a posedge is sampled per standard setup semantics; the value present before the edge is the one counted.
- No handshake and no state machine.

Optional Feature:
- Macro: MUX_SIMPLES_PARITY_EN.
- Defined: adds output y_par (1 bit) = registered even parity (XOR-reduce) of y.
  - Reset value 0.
  - Updated on the same edge as y_q.
- Undefined: the y_par port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_simples_pkg holds:
  - default WIDTH and CNT_W localparams;
  - a function sat_inc(value, width) used by the counter.
- One natural sub-module, mux_simples_cell: a pure combinational WIDTH-bit 2:1 selector (a, b, s -> y).
  - The top instantiates it and wraps the registers and counter around it.

Test Plan:
- Exhaustive truth table, WIDTH=1: step (a,b,s) through 000..111 at 1 ns intervals -> y = 0,0,0,1,1,0,1,1 respectively, with no clock activity required.
- Registered latency: a=0, b=1, s toggles 0->1 just before a posedge -> y changes immediately; y_q becomes 1 one cycle later.
- Toggle count: from reset, drive s=1,0,1,1,0 on 5 consecutive edges -> toggle_cnt = 1,2,3,3,4.
- Saturation, CNT_W=2: toggle s every cycle for 6 cycles -> toggle_cnt reaches 3 and holds at 3.
- Async reset mid-run: assert rst between clock edges while toggle_cnt=3 and y_q=1 -> both read 0 before the next edge; y still follows a/b/s.
- WIDTH=8 with MUX_SIMPLES_PARITY_EN: a=8'hA5, b=8'h01, s=1 -> y=8'h01, and after one edge y_q=8'h01, y_par=1.

Source files
------------

// File: rtl/mux_simples_pkg.sv
// Shared defaults and the saturating increment used by the mux_simples select-toggle counter.
package mux_simples_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  // Holds at 2^width-1 instead of wrapping; width is limited to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [63:0] lim;
    lim = (64'd1 << width) - 64'd1;
    return ({32'd0, value} >= lim) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mux_simples_cell.sv
// WIDTH-bit 2:1 selector, y = s ? b : a; purely combinational, zero latency.
// Backpressure: none, no handshake.
module mux_simples_cell #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_simples.sv
// 2:1 mux with zero-latency y, plus 1-cycle registered y_q/s_q and a saturating select-toggle count.
// Backpressure: none. MUX_SIMPLES_PARITY_EN adds y_par, the registered even parity of y.
module mux_simples
  import mux_simples_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] toggle_cnt,
`ifdef MUX_SIMPLES_PARITY_EN
  output logic             y_par,
`endif
  output logic             s_q
);

  mux_simples_cell #(.WIDTH(WIDTH)) u_cell (
    .a (a),
    .b (b),
    .s (s),
    .y (y)
  );

  // s_q resets to 0, so s=1 on the first edge after reset counts as a toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q        <= '0;
      s_q        <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      y_q <= y;
      s_q <= s;
      if (s != s_q) begin
        toggle_cnt <= CNT_W'(sat_inc(32'(toggle_cnt), CNT_W));
      end
    end
  end

`ifdef MUX_SIMPLES_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_par <= 1'b0;
    end else begin
      y_par <= ^y;
    end
  end
`endif

endmodule

// File: tb/tb_mux_simples.sv
// Directed checks of mux_simples: truth table, latency, toggle count, saturation, async reset, WIDTH=8.
module tb_mux_simples;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_vec = 0;
  int         n_err = 0;

  logic       a1 = 1'b0, b1 = 1'b0, s1 = 1'b0;
  logic       y1, y_q1, s_q1;
  logic [7:0] cnt1;

  logic       a2 = 1'b1, b2 = 1'b0, s2 = 1'b0;
  logic       y2, y_q2, s_q2;
  logic [1:0] cnt2;

  logic [7:0] a8 = 8'hA5, b8 = 8'h01;
  logic       s8 = 1'b0;
  logic [7:0] y8, y_q8, cnt8;
  logic       s_q8;
`ifdef MUX_SIMPLES_PARITY_EN
  logic       y_par1, y_par2, y_par8;
`endif

  always #5 clk = ~clk;

  mux_simples #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .s(s1), .y(y1), .y_q(y_q1),
    .toggle_cnt(cnt1),
`ifdef MUX_SIMPLES_PARITY_EN
    .y_par(y_par1),
`endif
    .s_q(s_q1)
  );

  mux_simples #(.WIDTH(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .s(s2), .y(y2), .y_q(y_q2),
    .toggle_cnt(cnt2),
`ifdef MUX_SIMPLES_PARITY_EN
    .y_par(y_par2),
`endif
    .s_q(s_q2)
  );

  mux_simples #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .s(s8), .y(y8), .y_q(y_q8),
    .toggle_cnt(cnt8),
`ifdef MUX_SIMPLES_PARITY_EN
    .y_par(y_par8),
`endif
    .s_q(s_q8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] abs;
    logic [7:0] tt;
    logic [4:0] seq1;
    logic [7:0] exp1 [5];
    logic [1:0] exp2 [6];

    tt   = 8'hD8;        // y for (a,b,s) = 000..111 -> 0,0,0,1,1,0,1,1
    seq1 = 5'b01101;     // applied LSB first: s = 1,0,1,1,0
    exp1 = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4};
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    // Truth table while reset is held: combinational path ignores clk and rst.
    for (int i = 0; i < 8; i++) begin
      abs = 3'(i);
      {a1, b1, s1} = abs;
      #1;
      check($sformatf("truth_%0d", i), 32'(y1), 32'(tt[i]));
    end
    check("rst_y_q",  32'(y_q1), 32'd0);
    check("rst_s_q",  32'(s_q1), 32'd0);
    check("rst_cnt",  32'(cnt1), 32'd0);
    check("rst_y_q8", 32'(y_q8), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b1; s1 = 1'b0;

    for (int k = 0; k < 5; k++) begin
      s1 = seq1[k];
      @(negedge clk);
      check($sformatf("toggle_cnt_%0d", k), 32'(cnt1), 32'(exp1[k]));
      check($sformatf("s_q_%0d", k), 32'(s_q1), 32'(seq1[k]));
      check($sformatf("y_q_%0d", k), 32'(y_q1), 32'(seq1[k]));
    end

    // s rises 2 ns before a posedge: y follows at once, y_q picks it up at that edge.
    @(posedge clk);
    #8;
    s1 = 1'b1;
    #1;
    check("lat_y_now",   32'(y1),   32'd1);
    check("lat_y_q_old", 32'(y_q1), 32'd0);
    @(posedge clk);
    #1;
    check("lat_y_q_new", 32'(y_q1), 32'd1);
    check("lat_cnt",     32'(cnt1), 32'd5);

    // Saturation with CNT_W=2; a=1,b=0 so y = ~s and ends at 1.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s2 = ~s2;
      @(negedge clk);
      check($sformatf("sat_cnt_%0d", k), 32'(cnt2), 32'(exp2[k]));
    end
    check("sat_y_q", 32'(y_q2), 32'd1);

    // Async reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt2", 32'(cnt2), 32'd0);
    check("arst_y_q2", 32'(y_q2), 32'd0);
    check("arst_s_q2", 32'(s_q2), 32'd0);
    check("arst_cnt1", 32'(cnt1), 32'd0);
    s2 = 1'b1;
    #1;
    check("arst_y2_s1", 32'(y2), 32'd0);
    s2 = 1'b0;
    #1;
    check("arst_y2_s0", 32'(y2), 32'd1);

    // First edge after release compares s=1 against s_q=0.
    @(negedge clk);
    rst = 1'b0;
    s1 = 1'b1;
    @(negedge clk);
    check("first_edge_cnt1", 32'(cnt1), 32'd1);
    check("first_edge_cnt2", 32'(cnt2), 32'd0);

    // WIDTH=8 bus.
    s8 = 1'b1;
    #1;
    check("w8_y_b", 32'(y8), 32'h01);
    @(negedge clk);
    check("w8_y_q_b", 32'(y_q8), 32'h01);
`ifdef MUX_SIMPLES_PARITY_EN
    check("w8_par_b", 32'(y_par8), 32'd1);
`endif
    s8 = 1'b0;
    #1;
    check("w8_y_a", 32'(y8), 32'hA5);
    @(negedge clk);
    check("w8_y_q_a", 32'(y_q8), 32'hA5);
`ifdef MUX_SIMPLES_PARITY_EN
    check("w8_par_a", 32'(y_par8), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
